// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux. Grants one requester at a time,
// drives the mux select and preempts an owner that has held the mux for
// MAX_HOLD cycles while someone else is waiting.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,  // 0 disables the hold limit
  parameter int unsigned CNT_W    = 4   // must satisfy 2**CNT_W > MAX_HOLD
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       valid_o,
  output logic       gnt_chg_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [CNT_W-1:0] HoldLim = CNT_W'(MAX_HOLD);
  localparam bit               NoLimit = (MAX_HOLD == 0);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             chg_q, chg_d;

  logic [2:0] win_idle, win_rot;  // {found, index}
  logic [1:0] rot_ptr;
  logic       others_pending;
  logic       grant_en;
  logic [1:0] grant_idx;

  // First requester at or after base, wrapping; the lowest offset wins.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  // Candidate winners: from the resting pointer, and from just past the owner.
  always_comb begin
    rot_ptr        = sel_q + 2'd1;
    win_idle       = pick(req_i, ptr_q);
    win_rot        = pick(req_i, rot_ptr);
    others_pending = |(req_i & ~gnt_q);
  end

  // Next-state logic: idle arbitration, release handover, hold-limit preemption.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    chg_d     = 1'b0;
    grant_en  = 1'b0;
    grant_idx = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (win_idle[2]) begin
          grant_en  = 1'b1;
          grant_idx = win_idle[1:0];
        end
      end
      StBusy: begin
        if (!req_i[sel_q]) begin
          // Owner released: rotate past it and hand over without a bubble.
          ptr_d = rot_ptr;
          if (win_rot[2]) begin
            grant_en  = 1'b1;
            grant_idx = win_rot[1:0];
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
          end
        end else if (!NoLimit && (hold_q == HoldLim)) begin
          // Hold limit reached: preempt only if someone else is waiting.
          if (others_pending) begin
            ptr_d     = rot_ptr;
            grant_en  = 1'b1;
            grant_idx = win_rot[1:0];
          end
        end else if (NoLimit ? (hold_q != '1) : (hold_q < HoldLim)) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase

    if (grant_en) begin
      state_d = StBusy;
      gnt_d   = 4'b0001 << grant_idx;
      sel_d   = grant_idx;
      hold_d  = CNT_W'(1);
      chg_d   = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      chg_q   <= chg_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign valid_o   = |gnt_q;
  assign gnt_chg_o = chg_q;

endmodule
